// File: rtl/mem_pkg.sv
// Types shared between the memory arbiter and the SPI flash/PSRAM controller.
package mem_pkg;

    typedef enum logic [1:0] {
        TYPE_IMEM_READ  = 2'd0,
        TYPE_DMEM_READ  = 2'd1,
        TYPE_DMEM_WRITE = 2'd2
    } mem_type_t;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE      = 2'd0;
    localparam arb_state_t ST_ISSUE     = 2'd1;
    localparam arb_state_t ST_WAIT_BUSY = 2'd2;
    localparam arb_state_t ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/spi_mem_arbiter.sv
// Shares the SPI memory controller between instruction fetch and data port,
// one transaction at a time, with a bounded data-first streak.
module spi_mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        fetch_req_in,
    input  logic [15:0] fetch_addr_in,
    output logic [15:0] fetch_data_out,
    output logic        fetch_done_out,
    input  logic        data_req_in,
    input  logic        data_we_in,
    input  logic [15:0] data_addr_in,
    input  logic [7:0]  data_wdata_in,
    output logic [7:0]  data_rdata_out,
    output logic        data_done_out,
    output logic [15:0] mem_addr_out,
    output logic        mem_addr_valid_out,
    output mem_type_t   mem_type_out,
    output logic [7:0]  mem_wdata_out,
    input  logic [15:0] mem_flash_data_in,
    input  logic        mem_flash_valid_in,
    input  logic [7:0]  mem_psram_data_in,
    input  logic        mem_psram_valid_in,
    input  logic        mem_busy_in,
    output logic        busy_out
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    arb_state_t  state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        is_fetch_q, is_fetch_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    mem_type_t   mem_type_q, mem_type_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        addr_valid_q, addr_valid_d;
    logic        busy_q, busy_d;
    logic [15:0] fetch_data_q, fetch_data_d;
    logic        fetch_done_q, fetch_done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        data_done_q, data_done_d;
    logic        take_fetch;
    logic        holdoff;

    // The cycle carrying a done pulse is skipped so a stale req is not regranted
    assign holdoff = fetch_done_q | data_done_q;

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        is_fetch_d   = is_fetch_q;
        mem_addr_d   = mem_addr_q;
        mem_type_d   = mem_type_q;
        mem_wdata_d  = mem_wdata_q;
        addr_valid_d = 1'b0;
        busy_d       = busy_q;
        fetch_data_d = fetch_data_q;
        fetch_done_d = 1'b0;
        rdata_d      = rdata_q;
        data_done_d  = 1'b0;
        take_fetch   = fetch_req_in && (!data_req_in || streak_q == STREAK_MAX);

        case (state_q)
            ST_IDLE: begin
                if (!fetch_req_in) streak_d = '0;
                if (!holdoff && !mem_busy_in && (fetch_req_in || data_req_in)) begin
                    mem_wdata_d  = data_wdata_in;
                    busy_d       = 1'b1;
                    addr_valid_d = 1'b1;
                    state_d      = ST_ISSUE;
                    if (take_fetch) begin
                        is_fetch_d = 1'b1;
                        mem_addr_d = fetch_addr_in;
                        mem_type_d = TYPE_IMEM_READ;
                        streak_d   = '0;
                    end else begin
                        is_fetch_d = 1'b0;
                        mem_addr_d = data_addr_in;
                        mem_type_d = data_we_in ? TYPE_DMEM_WRITE : TYPE_DMEM_READ;
                        if (fetch_req_in && streak_q != STREAK_MAX)
                            streak_d = streak_q + 4'd1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (mem_busy_in) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!mem_busy_in) begin
                    if (is_fetch_q) begin
                        if (mem_flash_valid_in) fetch_data_d = mem_flash_data_in;
                        fetch_done_d = 1'b1;
                    end else begin
                        if (mem_type_q == TYPE_DMEM_READ && mem_psram_valid_in)
                            rdata_d = mem_psram_data_in;
                        data_done_d = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= ST_IDLE;
            streak_q     <= '0;
            is_fetch_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_type_q   <= TYPE_IMEM_READ;
            mem_wdata_q  <= '0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            fetch_data_q <= '0;
            fetch_done_q <= 1'b0;
            rdata_q      <= '0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            is_fetch_q   <= is_fetch_d;
            mem_addr_q   <= mem_addr_d;
            mem_type_q   <= mem_type_d;
            mem_wdata_q  <= mem_wdata_d;
            addr_valid_q <= addr_valid_d;
            busy_q       <= busy_d;
            fetch_data_q <= fetch_data_d;
            fetch_done_q <= fetch_done_d;
            rdata_q      <= rdata_d;
            data_done_q  <= data_done_d;
        end
    end

    assign fetch_data_out     = fetch_data_q;
    assign fetch_done_out     = fetch_done_q;
    assign data_rdata_out     = rdata_q;
    assign data_done_out      = data_done_q;
    assign mem_addr_out       = mem_addr_q;
    assign mem_addr_valid_out = addr_valid_q;
    assign mem_type_out       = mem_type_q;
    assign mem_wdata_out      = mem_wdata_q;
    assign busy_out           = busy_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: behavioural SPI controller with flash/PSRAM
// arrays, directed plus randomized transactions checked against a memory model.
module tb_spi_mem_arbiter;
    import mem_pkg::*;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        fetch_req_in = 1'b0;
    logic [15:0] fetch_addr_in = '0;
    logic [15:0] fetch_data_out;
    logic        fetch_done_out;
    logic        data_req_in = 1'b0;
    logic        data_we_in = 1'b0;
    logic [15:0] data_addr_in = '0;
    logic [7:0]  data_wdata_in = '0;
    logic [7:0]  data_rdata_out;
    logic        data_done_out;
    logic [15:0] mem_addr_out;
    logic        mem_addr_valid_out;
    mem_type_t   mem_type_out;
    logic [7:0]  mem_wdata_out;
    logic [15:0] mem_flash_data_in = '0;
    logic        mem_flash_valid_in = 1'b0;
    logic [7:0]  mem_psram_data_in = '0;
    logic        mem_psram_valid_in = 1'b0;
    logic        mem_busy_in = 1'b0;
    logic        busy_out;

    spi_mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .fetch_req_in(fetch_req_in), .fetch_addr_in(fetch_addr_in),
        .fetch_data_out(fetch_data_out), .fetch_done_out(fetch_done_out),
        .data_req_in(data_req_in), .data_we_in(data_we_in),
        .data_addr_in(data_addr_in), .data_wdata_in(data_wdata_in),
        .data_rdata_out(data_rdata_out), .data_done_out(data_done_out),
        .mem_addr_out(mem_addr_out), .mem_addr_valid_out(mem_addr_valid_out),
        .mem_type_out(mem_type_out), .mem_wdata_out(mem_wdata_out),
        .mem_flash_data_in(mem_flash_data_in), .mem_flash_valid_in(mem_flash_valid_in),
        .mem_psram_data_in(mem_psram_data_in), .mem_psram_valid_in(mem_psram_valid_in),
        .mem_busy_in(mem_busy_in), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad = 0;
    int n_issue = 0;
    int overlap_err = 0;
    int cnt = 0;
    logic [7:0]  fl [0:65535];
    logic [7:0]  ps [0:65535];
    logic [7:0]  exp_ps [int];
    logic [15:0] l_addr = '0;
    mem_type_t   l_type = TYPE_IMEM_READ;
    logic [7:0]  l_wd = '0;

    function automatic logic [7:0] ps_init(int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [15:0] flash_word(logic [15:0] a);
        int ai;
        ai = int'({a[15:1], 1'b0});
        return {fl[ai], fl[ai+1]};
    endfunction

    function automatic logic [7:0] ps_expect(logic [15:0] a);
        if (exp_ps.exists(int'(a))) return exp_ps[int'(a)];
        return ps_init(int'(a));
    endfunction

    // Behavioural SPI controller: busy for a random 2..5 cycles per command
    always @(negedge clk_in) begin
        if (reset_in) begin
            mem_busy_in = 1'b0;
            mem_flash_valid_in = 1'b0;
            mem_psram_valid_in = 1'b0;
            cnt = 0;
        end else begin
            mem_flash_valid_in = 1'b0;
            mem_psram_valid_in = 1'b0;
            if (mem_addr_valid_out) begin
                if (mem_busy_in) overlap_err++;
                n_issue++;
                l_addr = mem_addr_out;
                l_type = mem_type_out;
                l_wd = mem_wdata_out;
                mem_busy_in = 1'b1;
                cnt = $urandom_range(1, 4);
            end else if (mem_busy_in) begin
                if (cnt == 0) begin
                    mem_busy_in = 1'b0;
                    case (l_type)
                        TYPE_IMEM_READ: begin
                            mem_flash_data_in = flash_word(l_addr);
                            mem_flash_valid_in = 1'b1;
                        end
                        TYPE_DMEM_READ: begin
                            mem_psram_data_in = ps[int'(l_addr)];
                            mem_psram_valid_in = 1'b1;
                        end
                        default: ps[int'(l_addr)] = l_wd;
                    endcase
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input logic [15:0] a, input bit hold_extra,
                            output logic [15:0] got);
        int k;
        fetch_addr_in = a;
        fetch_req_in = 1'b1;
        for (k = 0; k < 100; k++) begin
            tick();
            if (fetch_done_out) break;
        end
        chk("fetch_timeout", 32'(k < 100), 32'd1);
        got = fetch_data_out;
        if (hold_extra) tick();
        fetch_req_in = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [15:0] a, input logic [7:0] wd,
                           output logic [7:0] got);
        int k;
        data_we_in = we;
        data_addr_in = a;
        data_wdata_in = wd;
        data_req_in = 1'b1;
        for (k = 0; k < 100; k++) begin
            tick();
            if (data_done_out) break;
        end
        chk("data_timeout", 32'(k < 100), 32'd1);
        got = data_rdata_out;
        data_req_in = 1'b0;
    endtask

    initial begin
        logic [15:0] w16;
        logic [15:0] a;
        logic [7:0]  w8;
        logic [7:0]  prev;
        logic [7:0]  wd;
        logic [9:0]  order;
        int base;
        int nd;
        int nf;
        int fdone_at;
        int ddone_at;

        for (int i = 0; i < 65536; i++) begin
            fl[i] = 8'($urandom);
            ps[i] = ps_init(i);
        end
        fl[16'h001E] = 8'hAB;
        fl[16'h001F] = 8'hCD;

        repeat (3) tick();
        chk("rst_data", {fetch_data_out, data_rdata_out, mem_wdata_out}, 32'h0);
        chk("rst_ctl", {fetch_done_out, data_done_out, mem_addr_valid_out, busy_out}, 32'h0);
        chk("rst_addr", 32'(mem_addr_out), 32'h0);
        chk("rst_type", 32'(mem_type_out), 32'(TYPE_IMEM_READ));
        reset_in = 1'b0;
        repeat (2) tick();

        // Fetch only from an odd address
        base = n_issue;
        do_fetch(16'h001F, 1'b0, w16);
        chk("f1_data", 32'(w16), 32'h0000ABCD);
        chk("f1_busy", 32'(busy_out), 32'h0);
        chk("f1_addr", 32'(l_addr), 32'h001F);
        chk("f1_type", 32'(l_type), 32'(TYPE_IMEM_READ));
        chk("f1_issues", 32'(n_issue - base), 32'd1);

        // Write then read back
        prev = data_rdata_out;
        do_data(1'b1, 16'h0100, 8'h5A, w8);
        exp_ps[16'h0100] = 8'h5A;
        chk("wr_rdata_hold", 32'(w8), 32'(prev));
        chk("wr_wdata", 32'(mem_wdata_out), 32'h5A);
        chk("wr_type", 32'(l_type), 32'(TYPE_DMEM_WRITE));
        do_data(1'b0, 16'h0100, 8'h00, w8);
        chk("rd_data", 32'(w8), 32'h5A);
        chk("rd_type", 32'(l_type), 32'(TYPE_DMEM_READ));

        // Randomized single-requester traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    a = 16'($urandom);
                    do_fetch(a, 1'b0, w16);
                    chk("rnd_fetch", 32'(w16), 32'(flash_word(a)));
                end
                1: begin
                    a = 16'h0100 + 16'($urandom_range(0, 15));
                    wd = 8'($urandom);
                    prev = data_rdata_out;
                    do_data(1'b1, a, wd, w8);
                    exp_ps[int'(a)] = wd;
                    chk("rnd_write_hold", 32'(w8), 32'(prev));
                end
                default: begin
                    a = 16'h0100 + 16'($urandom_range(0, 15));
                    do_data(1'b0, a, 8'h00, w8);
                    chk("rnd_read", 32'(w8), 32'(ps_expect(a)));
                end
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end

        // Both requests held: data streak of 4 then a forced fetch
        base = n_issue;
        order = '0;
        nd = 0;
        data_we_in = 1'b0;
        data_addr_in = 16'h0100;
        fetch_addr_in = 16'h0040;
        fetch_req_in = 1'b1;
        data_req_in = 1'b1;
        for (int k = 0; k < 400 && nd < 10; k++) begin
            tick();
            if (fetch_done_out) begin order = {order[8:0], 1'b1}; nd++; end
            if (data_done_out) begin order = {order[8:0], 1'b0}; nd++; end
        end
        fetch_req_in = 1'b0;
        data_req_in = 1'b0;
        repeat (3) tick();
        chk("streak_order", 32'(order), 32'h021);
        chk("streak_dones", 32'(nd), 32'd10);
        chk("streak_issues", 32'(n_issue - base), 32'd10);
        chk("streak_rdata", 32'(data_rdata_out), 32'(ps_expect(16'h0100)));

        // Requester keeps req one cycle past done
        base = n_issue;
        do_fetch(16'h0222, 1'b1, w16);
        repeat (4) tick();
        chk("stale_issues", 32'(n_issue - base), 32'd1);
        chk("stale_data", 32'(w16), 32'(flash_word(16'h0222)));

        // Asynchronous reset in the middle of a flash read
        fetch_addr_in = 16'h0300;
        fetch_req_in = 1'b1;
        for (int k = 0; k < 50 && !mem_busy_in; k++) tick();
        tick();
        #2 reset_in = 1'b1;
        #1;
        chk("arst_ctl", {fetch_done_out, data_done_out, mem_addr_valid_out, busy_out}, 32'h0);
        chk("arst_data", {fetch_data_out, data_rdata_out, mem_wdata_out}, 32'h0);
        chk("arst_addr", 32'(mem_addr_out), 32'h0);
        fetch_req_in = 1'b0;
        nf = 0;
        repeat (3) begin
            tick();
            if (fetch_done_out) nf++;
        end
        reset_in = 1'b0;
        repeat (3) begin
            tick();
            if (fetch_done_out) nf++;
        end
        chk("arst_no_done", 32'(nf), 32'd0);
        do_fetch(16'h0301, 1'b0, w16);
        chk("arst_refetch", 32'(w16), 32'(flash_word(16'h0301)));

        // Data request raised while a fetch is outstanding
        base = n_issue;
        fdone_at = -1;
        ddone_at = -1;
        fetch_addr_in = 16'h0456;
        fetch_req_in = 1'b1;
        for (int k = 0; k < 50 && !mem_busy_in; k++) tick();
        tick();
        data_we_in = 1'b0;
        data_addr_in = 16'h0105;
        data_req_in = 1'b1;
        for (int k = 0; k < 200 && ddone_at < 0; k++) begin
            tick();
            if (fetch_done_out) begin
                fdone_at = k;
                fetch_req_in = 1'b0;
                chk("pend_fetch_data", 32'(fetch_data_out), 32'(flash_word(16'h0456)));
                chk("pend_issue_at_fdone", 32'(n_issue - base), 32'd1);
            end
            if (data_done_out) begin
                ddone_at = k;
                data_req_in = 1'b0;
            end
        end
        fetch_req_in = 1'b0;
        data_req_in = 1'b0;
        chk("pend_order", 32'(fdone_at >= 0 && ddone_at > fdone_at), 32'd1);
        chk("pend_rdata", 32'(data_rdata_out), 32'(ps_expect(16'h0105)));
        chk("pend_issues", 32'(n_issue - base), 32'd2);
        chk("no_overlap", 32'(overlap_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
Sequences and shares the single SPI memory controller (flash instruction reads, PSRAM data reads/writes) between the CPU instruction-fetch port and the CPU data port. Accepts one request at a time and converts it into a one-cycle addr_valid/mem_type command to the SPI controller. Tracks the controller's busy/valid handshake and routes the result back to the requester with a one-cycle done pulse. Sits between the CPU core and spi_flash_controller.

Parameters:
MAX_DATA_STREAK, 4, consecutive data-port grants allowed while a fetch is pending before fetch is forced ahead (1..15)

Ports:
clk_in  input  1  system clock
reset_in  input  1  asynchronous, active-high reset
fetch_req_in  input  1  instruction fetch request; held until fetch_done_out
fetch_addr_in  input  16  fetch address; bit 0 ignored downstream
fetch_data_out  output  16  fetched word, {byte[addr], byte[addr+1]}
fetch_done_out  output  1  one-cycle completion pulse for fetch
data_req_in  input  1  data access request; held until data_done_out
data_we_in  input  1  1 = PSRAM write, 0 = PSRAM read
data_addr_in  input  16  data byte address
data_wdata_in  input  8  write byte
data_rdata_out  output  8  read byte
data_done_out  output  1  one-cycle completion pulse for data access (read or write)
mem_addr_out  output  16  to SPI controller addr_in
mem_addr_valid_out  output  1  to SPI controller addr_valid_in; one-cycle pulse
mem_type_out  output  mem_type_t  to SPI controller mem_type_in
mem_wdata_out  output  8  to SPI controller psram_data_in
mem_flash_data_in  input  16  from SPI controller flash_data_out
mem_flash_valid_in  input  1  from SPI controller flash_data_valid_out
mem_psram_data_in  input  8  from SPI controller psram_data_out
mem_psram_valid_in  input  1  from SPI controller psram_data_valid_out
mem_busy_in  input  1  from SPI controller busy_out
busy_out  output  1  high from grant until the done pulse

Behaviour:
- One clock, clk_in. Reset is asynchronous and active-high on reset_in. All state is reset asynchronously.
- Reset values: all outputs 0; mem_type_out = TYPE_IMEM_READ; state IDLE; streak counter 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE, arbitration, evaluated only when mem_busy_in = 0:
  - data_req_in only -> grant data.
  - fetch_req_in only -> grant fetch.
  - Both requests high -> grant data, unless streak == MAX_DATA_STREAK, in which case grant fetch.
  - On grant: register address, type and wdata onto the mem_* outputs; busy_out <= 1; go to ISSUE.
  - Type mapping: fetch -> TYPE_IMEM_READ; data with we=0 -> TYPE_DMEM_READ; data with we=1 -> TYPE_DMEM_WRITE.
- Streak counter:
  - Increments, saturating at MAX_DATA_STREAK, on a data grant while fetch_req_in = 1.
  - Clears on a fetch grant, or on any IDLE cycle with fetch_req_in = 0.
- ISSUE: mem_addr_valid_out = 1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for mem_busy_in = 1, then go to WAIT_DONE. mem_addr_valid_out stays 0.
- WAIT_DONE: on mem_busy_in = 0:
  - Fetch: capture mem_flash_data_in into fetch_data_out if mem_flash_valid_in = 1.
  - Data read: capture mem_psram_data_in into data_rdata_out if mem_psram_valid_in = 1.
  - Write: no data is captured.
  - Then pulse the matching done output for 1 cycle, clear busy_out, and go to IDLE.
- Done pulse: asserted in the cycle after busy falls. The requester drops req in that same cycle. The arbiter ignores req for one cycle after done (the IDLE entry cycle re-arbitrates only from the next cycle), so a stale req never causes a double grant.
- mem_addr_out, mem_type_out and mem_wdata_out stay stable from ISSUE until the next grant.
- fetch_data_out and data_rdata_out hold their values until overwritten by the next completion of the same kind.
- Requests arriving mid-transaction stay pending; they are neither lost nor merged.
- Reset mid-transaction: immediate return to IDLE with outputs at reset values and no done pulse. The SPI controller shares reset_in, so both sides restart consistently.
- Minimum turnaround: req seen in IDLE at cycle N -> mem_addr_valid_out at N+1 -> controller busy from N+2.

Decomposition:
- Shared package mem_pkg holds:
  - mem_type_t (2-bit enum: TYPE_IMEM_READ, TYPE_DMEM_READ, TYPE_DMEM_WRITE), shared with the SPI controller.
  - The arbiter state enum.
- No sub-module. Arbitration plus the streak counter is small enough to stay inline.

Test Plan:
- Fetch only, addr 0x001F, flash model holds 0x1E=0xAB, 0x1F=0xCD -> one mem_addr_valid pulse, mem_addr_out=0x001F, type IMEM_READ; fetch_data_out=0xABCD with a single fetch_done pulse; busy_out low afterwards.
- Data write 0x5A to 0x0100, then data read from 0x0100 -> write gives data_done with no rdata change; read gives data_rdata_out=0x5A; mem_wdata_out=0x5A during the write.
- fetch_req and data_req both held continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F; exactly one done per grant.
- Requester holds req one cycle past done -> no second mem_addr_valid pulse for that request.
- reset_in asserted during WAIT_DONE of a flash read -> all outputs 0 asynchronously; no done pulse; a new fetch after reset completes normally.
- data_req raised while a fetch is in WAIT_DONE -> data granted only after fetch_done; mem_addr_valid pulses never overlap with controller busy.
